// File: rtl/jk_bank_sequencer_if.sv
// ---------------------------------------------------------------------------
// jk_bank_sequencer_if
// Command bus between the requesters and the JK bank sequencer.
//   req_valid  per-requester command valid
//   req_ready  per-requester accept (one-hot or zero)
//   req_op     per-requester op, slice i = [2i+1:2i]
//              (00 hold, 01 reset, 10 set, 11 toggle)
//   req_addr   per-requester target bit index, slice i = [AW*i +: AW]
//   req_cnt    per-requester repeat count, slice i = [CNT_W*i +: CNT_W]
// master: requester side, slave: sequencer side.
// ---------------------------------------------------------------------------
interface jk_bank_sequencer_if #(
  parameter int NREQ  = 4,
  parameter int AW    = 3,
  parameter int CNT_W = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [AW*NREQ-1:0]    req_addr;
  logic [CNT_W*NREQ-1:0] req_cnt;

  modport master (
    output req_valid,
    output req_op,
    output req_addr,
    output req_cnt,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_addr,
    input  req_cnt,
    output req_ready
  );
endinterface

// File: rtl/jk_bank_sequencer.sv
// ---------------------------------------------------------------------------
// jk_bank_sequencer
// Round-robin arbiter plus sequencer for a WIDTH-bit bank of JK cells.
// One command is accepted per IDLE cycle; the accepted op is applied to
// q[addr] for cnt clock edges (cnt 0 counts as 1), then done pulses.
// Ports:
//   clk       single clock, rising edge
//   rst       synchronous active-high reset
//   bus       command bus (slave modport of jk_bank_sequencer_if)
//   q         JK bank contents
//   busy      high while a command executes
//   grant_id  requester owning the current or last command
//   done      one-cycle pulse after the final apply edge
//   err       pulse with done when the command's addr was >= WIDTH
// ---------------------------------------------------------------------------
module jk_bank_sequencer #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 3,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  jk_bank_sequencer_if.slave       bus,
  output logic [WIDTH-1:0]         q,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     done,
  output logic                     err
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;

  logic [GW-1:0]     last_grant_r;
  logic [GW-1:0]     grant_r;
  logic [GW-1:0]     sel_s;
  logic              found_s;
  logic              accept_s;
  logic              last_edge_s;
  logic [NREQ-1:0]   ready_s;

  logic [1:0]        sel_op_s;
  logic [AW-1:0]     sel_addr_s;
  logic [CNT_W-1:0]  sel_cnt_s;
  logic [CNT_W-1:0]  cap_cnt_s;

  logic [1:0]        op_r;
  logic [AW-1:0]     addr_r;
  logic [CNT_W-1:0]  remaining_r;
  logic              in_range_s;

  logic [WIDTH-1:0]  q_r;
  logic [WIDTH-1:0]  q_nxt_s;
  logic              done_r;
  logic              err_r;

  // Characteristic equation of a JK cell: Q+ = J&~Q | ~K&Q.
  function automatic logic jk_next(input logic j, input logic k, input logic qc);
    return (j & ~qc) | (~k & qc);
  endfunction

  // Round-robin search: first valid requester above last_grant, wrapping.
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found_s && bus.req_valid[(int'(last_grant_r) + k) % NREQ]) begin
        found_s = 1'b1;
        sel_s   = GW'((int'(last_grant_r) + k) % NREQ);
      end else begin
        sel_s   = sel_s;
      end
    end
  end

  // Payload of the selected requester; a zero count still applies once.
  always_comb begin
    sel_op_s   = bus.req_op[2*int'(sel_s) +: 2];
    sel_addr_s = bus.req_addr[AW*int'(sel_s) +: AW];
    sel_cnt_s  = bus.req_cnt[CNT_W*int'(sel_s) +: CNT_W];
    if (sel_cnt_s == {CNT_W{1'b0}}) begin
      cap_cnt_s = {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cap_cnt_s = sel_cnt_s;
    end
  end

  // Next-state and handshake decode; ready is held low while rst is high.
  always_comb begin
    state_nxt_s = state_r;
    ready_s     = '0;
    accept_s    = 1'b0;
    last_edge_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s && !rst) begin
          ready_s     = {{(NREQ-1){1'b0}}, 1'b1} << sel_s;
          accept_s    = 1'b1;
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // remaining is never 0 here; <= keeps a corrupted count from locking up.
        if (remaining_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
          last_edge_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Apply the active op to the addressed cell only; out-of-range matches no cell.
  always_comb begin
    in_range_s = (int'(addr_r) < WIDTH);
    q_nxt_s    = q_r;
    for (int b = 0; b < WIDTH; b++) begin
      if ((state_r == ST_EXEC) && (addr_r == AW'(b))) begin
        q_nxt_s[b] = jk_next(op_r[1], op_r[0], q_r[b]);
      end else begin
        q_nxt_s[b] = q_r[b];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Command capture, repeat counter, bank contents and completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r          <= '0;
      op_r         <= 2'b00;
      addr_r       <= '0;
      remaining_r  <= '0;
      last_grant_r <= GW'(NREQ - 1);
      grant_r      <= '0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      done_r <= last_edge_s;
      err_r  <= last_edge_s & ~in_range_s;
      if (accept_s) begin
        op_r         <= sel_op_s;
        addr_r       <= sel_addr_s;
        remaining_r  <= cap_cnt_s;
        last_grant_r <= sel_s;
        grant_r      <= sel_s;
      end else if (state_r == ST_EXEC) begin
        remaining_r  <= remaining_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        remaining_r  <= remaining_r;
      end
    end
  end

  assign bus.req_ready = ready_s;
  assign q             = q_r;
  assign busy          = (state_r == ST_EXEC);
  assign grant_id      = grant_r;
  assign done          = done_r;
  assign err           = err_r;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jk_bank_sequencer
// Table of single-requester commands with hand-derived bank contents, plus
// hand-written sequences for per-edge toggling, round-robin fairness and
// reset during execution. Completed commands are checked by a scoreboard.
// ---------------------------------------------------------------------------
module tb_jk_bank_sequencer;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int AW    = 4;
  localparam int CNT_W = 4;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic [1:0]       grant_id;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  jk_bank_sequencer_if #(.NREQ(NREQ), .AW(AW), .CNT_W(CNT_W)) bus ();

  jk_bank_sequencer #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .q        (q),
    .busy     (busy),
    .grant_id (grant_id),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    int               r;
    logic [1:0]       op;
    logic [AW-1:0]    addr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] exp_q;
    logic             exp_err;
    int               exp_busy;
  } vec_t;

  typedef struct {
    int               grant;
    logic [WIDTH-1:0] q;
    logic             err;
    int               busy;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int g, input logic [WIDTH-1:0] eq, input logic ee, input int eb);
    exp_t e;
    e.grant = g;
    e.q     = eq;
    e.err   = ee;
    e.busy  = eb;
    sb_q.push_back(e);
  endtask

  // Scoreboard side: every done pulse must match the oldest pending command.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: actual done=1 required no pending command");
      end else begin
        mon_e = sb_q.pop_front();
        chk("done_grant", 32'(grant_id), 32'(mon_e.grant));
        chk("done_q",     32'(q),        32'(mon_e.q));
        chk("done_err",   32'(err),      32'(mon_e.err));
        chk("busy_len",   32'(busy_cnt), 32'(mon_e.busy));
      end
      busy_cnt = 0;
    end else if (err === 1'b1) begin
      chk("err_without_done", 32'(err), 32'd0);
    end
    if (rst === 1'b1) begin
      busy_cnt = 0;
    end else if (busy === 1'b1) begin
      busy_cnt++;
    end
  end

  task automatic issue(input int r, input logic [1:0] op, input logic [AW-1:0] addr,
                       input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] eq,
                       input logic ee, input int eb, input bit do_push);
    int              waited;
    logic [NREQ-1:0] onehot;
    waited    = 0;
    onehot    = '0;
    onehot[r] = 1'b1;
    @(negedge clk);
    bus.req_valid[r]                = 1'b1;
    bus.req_op[2*r +: 2]            = op;
    bus.req_addr[AW*r +: AW]        = addr;
    bus.req_cnt[CNT_W*r +: CNT_W]   = cnt;
    #1;
    while (bus.req_ready[r] !== 1'b1 && waited < 300) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("ready_onehot", 32'(bus.req_ready), 32'(onehot));
    if (do_push) push_exp(r, eq, ee, eb);
    @(posedge clk);
    #1;
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb_q.size() != 0 || busy !== 1'b0) && w < 400) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("drain_idle", 32'(sb_q.size() != 0 || busy !== 1'b0), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[13];
  int   ids[4];
  int   cycs[4];
  int   exp_ids[4];
  int   n;
  logic [NREQ-1:0] acc;

  initial begin
    // r, op, addr, cnt, expected q after done, expected err, expected busy length
    vecs[0]  = '{0, OP_SET,  4'd3,  4'd1,  8'h08, 1'b0, 1};
    vecs[1]  = '{1, OP_TOG,  4'd0,  4'd5,  8'h09, 1'b0, 5};
    vecs[2]  = '{2, OP_SET,  4'd7,  4'd0,  8'h89, 1'b0, 1};
    vecs[3]  = '{3, OP_HOLD, 4'd7,  4'd3,  8'h89, 1'b0, 3};
    vecs[4]  = '{0, OP_SET,  4'd1,  4'd2,  8'h8B, 1'b0, 2};
    vecs[5]  = '{1, OP_TOG,  4'd2,  4'd1,  8'h8F, 1'b0, 1};
    vecs[6]  = '{2, OP_SET,  4'd4,  4'd1,  8'h9F, 1'b0, 1};
    vecs[7]  = '{3, OP_TOG,  4'd5,  4'd3,  8'hBF, 1'b0, 3};
    vecs[8]  = '{0, OP_SET,  4'd6,  4'd15, 8'hFF, 1'b0, 15};
    vecs[9]  = '{1, OP_RST,  4'd7,  4'd0,  8'h7F, 1'b0, 1};
    vecs[10] = '{0, OP_SET,  4'd9,  4'd2,  8'h7F, 1'b1, 2};
    vecs[11] = '{2, OP_RST,  4'd0,  4'd1,  8'h7E, 1'b0, 1};
    vecs[12] = '{3, OP_TOG,  4'd15, 4'd1,  8'h7E, 1'b1, 1};
    exp_ids  = '{2, 3, 0, 2};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_cnt   = '0;
    repeat (2) @(posedge clk);

    // Reset state, with every requester valid to show ready is suppressed.
    @(negedge clk);
    bus.req_valid = '1;
    #1;
    chk("rst_ready",    32'(bus.req_ready), 32'd0);
    chk("rst_q",        32'(q),             32'd0);
    chk("rst_busy",     32'(busy),          32'd0);
    chk("rst_done",     32'(done),          32'd0);
    chk("rst_err",      32'(err),           32'd0);
    chk("rst_grant_id", 32'(grant_id),      32'd0);
    bus.req_valid = '0;
    rst = 1'b0;

    // Table of commands, one requester valid at a time.
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].r, vecs[i].op, vecs[i].addr, vecs[i].cnt,
            vecs[i].exp_q, vecs[i].exp_err, vecs[i].exp_busy, 1'b1);
    end
    drain();

    // Toggle addr 0 five times from a cleared bank, checked edge by edge.
    do_reset();
    issue(1, OP_TOG, 4'd0, 4'd5, 8'h01, 1'b0, 5, 1'b1);
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      chk("toggle_edge_q", 32'(q), (e % 2 == 1) ? 32'h01 : 32'h00);
    end
    drain();

    // Round robin: last_grant=0, requesters 0,2,3 continuously valid.
    issue(0, OP_HOLD, 4'd0, 4'd1, 8'h01, 1'b0, 1, 1'b1);
    @(negedge clk);
    for (int r = 0; r < NREQ; r++) begin
      bus.req_op[2*r +: 2]          = OP_HOLD;
      bus.req_addr[AW*r +: AW]      = 4'd2;
      bus.req_cnt[CNT_W*r +: CNT_W] = 4'd1;
    end
    bus.req_valid = 4'b1101;
    ids  = '{-1, -1, -1, -1};
    cycs = '{0, 0, 0, 0};
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      @(negedge clk);
      #1;
      if (busy === 1'b1) chk("ready_in_exec", 32'(bus.req_ready), 32'd0);
      acc = bus.req_valid & bus.req_ready;
      if (acc != '0) begin
        for (int r = 0; r < NREQ; r++) begin
          if (acc[r]) ids[n] = r;
        end
        cycs[n] = cyc;
        push_exp(ids[n], 8'h01, 1'b0, 1);
        n++;
        if (n == 4) begin
          @(posedge clk);
          #1;
          bus.req_valid = '0;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk("rr_order", 32'(ids[k]), 32'(exp_ids[k]));
    end
    for (int k = 1; k < 4; k++) begin
      chk("rr_spacing", 32'(cycs[k] - cycs[k-1]), 32'd2);
    end
    bus.req_valid = '0;
    drain();

    // Reset in the middle of a long toggle: abort, no done, pointer restored.
    issue(2, OP_TOG, 4'd1, 4'd10, 8'h00, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_pre_q", 32'(q), 32'h03);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_q",    32'(q),    32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_cnt   = {4{4'd1}};
    bus.req_valid = '1;
    #1;
    chk("abort_rst_ready", 32'(bus.req_ready), 32'd0);
    chk("abort_done2",     32'(done),          32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_next_ready", 32'(bus.req_ready), 32'h1);
    push_exp(0, 8'h00, 1'b0, 1);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    chk("abort_next_grant", 32'(grant_id), 32'd0);
    drain();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
